// File: rtl/arm_fetch_pkg.sv
// arm_fetch_pkg: shared types and constants
// for the ARM instruction fetch stage.
package arm_fetch_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] RESET_VECTOR_DEF = 32'h0000_0000;

  localparam logic [XLEN-1:0] ADDR_INC = 32'd4;

  typedef struct packed {
    logic [XLEN-1:0] word;
    logic [XLEN-1:0] addr;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] word_align(
    input logic [XLEN-1:0] a
  );
    return {a[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/arm_fetch_queue.sv
// arm_fetch_queue: prefetch FIFO of {word, addr}
// entries with a registered head and clear.
module arm_fetch_queue
  import arm_fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clear,
  input  logic                         push,
  input  fetch_entry_t                 din,
  input  logic                         pop,
  output fetch_entry_t                 head,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         empty,
  output logic                         full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  fetch_entry_t mem [DEPTH];

  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_nxt;
  logic [CW-1:0] count_q;
  logic          do_pop;
  logic          do_push;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign count   = count_q;
  assign rd_nxt  = rd_ptr + AW'(1);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // Storage array; needs no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push && !clear)
      mem[wr_ptr] <= din;
  end

  // Pointers and occupancy; clear wins over push and pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else if (clear) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_pop)
        rd_ptr <= rd_nxt;
      if (do_push)
        wr_ptr <= wr_ptr + AW'(1);
      count_q <= count_q
               + CW'(do_push)
               - CW'(do_pop);
    end
  end

  // Registered head; keeps its last value when the queue drains.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head <= '0;
    end else if (!clear) begin
      if (do_pop) begin
        if (count_q > CW'(1))
          head <= mem[rd_nxt];
        else if (do_push)
          head <= din;
      end else if (empty && do_push) begin
        head <= din;
      end
    end
  end

endmodule

// File: rtl/arm_fetch_unit.sv
// arm_fetch_unit: sequential fetch, req/ack memory
// port, prefetch queue and flush redirect.
module arm_fetch_unit
  import arm_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEF,
  parameter int          DEPTH        = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        flush,
  input  logic [31:0] flush_addr,
  output logic        code_valid,
  output logic [31:0] code,
  output logic [31:0] code_pc,
  input  logic        code_ready
);

  localparam int CW = $clog2(DEPTH+1);

  logic          live;
  logic          pending;
  logic          drop;
  logic [31:0]   pc;
  logic [31:0]   pend_addr;
  logic          ack_ok;
  logic          q_push;
  logic          q_pop;
  logic          q_empty;
  logic          q_full;
  logic [CW-1:0] q_count;
  fetch_entry_t  q_din;
  fetch_entry_t  q_head;

  assign imem_req  = live & (~q_full | pending);
  assign imem_addr = pending ? pend_addr : pc;

  assign ack_ok = imem_ack & imem_req;
  assign q_push = ack_ok & ~drop & ~flush;
  assign q_pop  = code_valid & code_ready;

  assign q_din.word = imem_rdata;
  assign q_din.addr = pc;

  assign code_valid = ~q_empty;
  assign code       = q_head.word;
  assign code_pc    = q_head.addr;

  arm_fetch_queue #(
    .DEPTH (DEPTH)
  ) u_queue (
    .clk   (clk),
    .rst   (rst),
    .clear (flush),
    .push  (q_push),
    .din   (q_din),
    .pop   (q_pop),
    .head  (q_head),
    .count (q_count),
    .empty (q_empty),
    .full  (q_full)
  );

  // Holds imem_req low until the first cycle after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      live <= 1'b0;
    else
      live <= 1'b1;
  end

  // Outstanding request tracking; address frozen until acked.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending   <= 1'b0;
      pend_addr <= RESET_VECTOR;
    end else begin
      pending <= imem_req & ~imem_ack;
      if (imem_req && !imem_ack && !pending)
        pend_addr <= pc;
    end
  end

  // Flush redirects pc and marks an unacked request for discard.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc   <= RESET_VECTOR;
      drop <= 1'b0;
    end else if (flush) begin
      pc   <= word_align(flush_addr);
      drop <= imem_req & ~imem_ack;
    end else if (ack_ok) begin
      if (!drop)
        pc <= pc + ADDR_INC;
      drop <= 1'b0;
    end
  end

  logic unused_cnt;
  assign unused_cnt = ^q_count;

endmodule
